// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC-V style main control FSM: FETCH/DECODE/EXEC/MEM/WB with a
// sticky TRAP on illegal opcodes or memory handshake timeout.
module multi_cycle_control #(
   parameter int                      ALU_OP_WIDTH   = 3,
   parameter logic [ALU_OP_WIDTH-1:0] FETCH_ALU_OP   = 3'b110,
   parameter int                      TIMEOUT_CYCLES = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              OP_i,
   input  logic                    Mem_Ready_i,
   output logic                    PC_Write_o,
   output logic                    IR_Write_o,
   output logic                    IorD_o,
   output logic                    Mem_Read_o,
   output logic                    Mem_Write_o,
   output logic                    Reg_Write_o,
   output logic                    Mem_to_Reg_o,
   output logic                    Branch_o,
   output logic                    Jump_o,
   output logic                    Imm_plus_reg_o,
   output logic                    ALU_Src_o,
   output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
   output logic                    Trap_o,
   output logic [2:0]              State_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   // Class encoding doubles as the ALU_Op code driven in EXEC.
   typedef enum logic [2:0] {
      C_R    = 3'd0,
      C_I    = 3'd1,
      C_U    = 3'd2,
      C_B    = 3'd3,
      C_JALR = 3'd4,
      C_S    = 3'd5,
      C_LOAD = 3'd6,
      C_JAL  = 3'd7
   } class_t;

   localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

   state_t     state, state_next, out_state;
   class_t     cls_q, cls_dec;
   logic       legal;
   logic [7:0] wait_cnt;
   logic       timed_out;
   logic       enter_wait;

   always_comb begin
      cls_dec = C_R;
      legal   = 1'b1;
      case (OP_i)
         7'h33:   cls_dec = C_R;
         7'h13:   cls_dec = C_I;
         7'h37:   cls_dec = C_U;
         7'h63:   cls_dec = C_B;
         7'h67:   cls_dec = C_JALR;
         7'h23:   cls_dec = C_S;
         7'h03:   cls_dec = C_LOAD;
         7'h6F:   cls_dec = C_JAL;
         default: legal   = 1'b0;
      endcase
   end

   assign timed_out  = !Mem_Ready_i && (wait_cnt == TIMEOUT);
   assign enter_wait = (state_next != state) &&
                       (state_next == S_FETCH || state_next == S_MEM);

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // pre-edge values; blocking here would let later reads see the new state.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cls_q    <= C_R;
         wait_cnt <= '0;
      end else begin
         if (state == S_DECODE && state_next == S_EXEC) cls_q <= cls_dec;
         if (enter_wait)
            wait_cnt <= '0;
         else if ((state == S_FETCH || state == S_MEM) && !Mem_Ready_i)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = Mem_Ready_i ? S_DECODE : (timed_out ? S_TRAP : S_FETCH);
         S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (cls_q)
               C_S, C_LOAD: state_next = S_MEM;
               C_B:         state_next = S_FETCH;
               default:     state_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (Mem_Ready_i)    state_next = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            else if (timed_out) state_next = S_TRAP;
            else                state_next = S_MEM;
         end
         S_WB:     state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_FETCH;
      endcase
   end

   // While reset is held the outputs look like an idle FETCH, whatever the register holds.
   assign out_state = reset ? S_FETCH : state;
   assign State_o   = state;

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      PC_Write_o     = 1'b0;
      IR_Write_o     = 1'b0;
      IorD_o         = 1'b0;
      Mem_Read_o     = 1'b0;
      Mem_Write_o    = 1'b0;
      Reg_Write_o    = 1'b0;
      Mem_to_Reg_o   = 1'b0;
      Branch_o       = 1'b0;
      Jump_o         = 1'b0;
      Imm_plus_reg_o = 1'b0;
      ALU_Src_o      = 1'b0;
      ALU_Op_o       = '0;
      Trap_o         = 1'b0;
      case (out_state)
         S_FETCH: begin
            Mem_Read_o = 1'b1;
            ALU_Op_o   = FETCH_ALU_OP;
            IR_Write_o = Mem_Ready_i && !reset;
            PC_Write_o = Mem_Ready_i && !reset;
         end
         S_EXEC: begin
            ALU_Op_o       = ALU_OP_WIDTH'(cls_q);
            ALU_Src_o      = (cls_q != C_R) && (cls_q != C_B);
            Branch_o       = (cls_q == C_B);
            Jump_o         = (cls_q == C_JAL) || (cls_q == C_JALR);
            PC_Write_o     = (cls_q == C_JAL) || (cls_q == C_JALR);
            Imm_plus_reg_o = (cls_q == C_JALR);
         end
         S_MEM: begin
            IorD_o      = 1'b1;
            ALU_Src_o   = 1'b1;
            Mem_Read_o  = (cls_q == C_LOAD);
            Mem_Write_o = (cls_q == C_S);
         end
         S_WB: begin
            Reg_Write_o  = 1'b1;
            Mem_to_Reg_o = (cls_q == C_LOAD);
         end
         S_TRAP:  Trap_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle expected state, ALU op and
// strobes, written out by hand for each instruction class and fault path.
module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] OP_i;
   logic       Mem_Ready_i;
   logic       PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o;
   logic       Reg_Write_o, Mem_to_Reg_o, Branch_o, Jump_o, Imm_plus_reg_o;
   logic       ALU_Src_o, Trap_o;
   logic [2:0] ALU_Op_o;
   logic [2:0] State_o;

   int tests = 0;
   int fails = 0;

   multi_cycle_control dut (
      .clk            (clk),
      .reset          (reset),
      .OP_i           (OP_i),
      .Mem_Ready_i    (Mem_Ready_i),
      .PC_Write_o     (PC_Write_o),
      .IR_Write_o     (IR_Write_o),
      .IorD_o         (IorD_o),
      .Mem_Read_o     (Mem_Read_o),
      .Mem_Write_o    (Mem_Write_o),
      .Reg_Write_o    (Reg_Write_o),
      .Mem_to_Reg_o   (Mem_to_Reg_o),
      .Branch_o       (Branch_o),
      .Jump_o         (Jump_o),
      .Imm_plus_reg_o (Imm_plus_reg_o),
      .ALU_Src_o      (ALU_Src_o),
      .ALU_Op_o       (ALU_Op_o),
      .Trap_o         (Trap_o),
      .State_o        (State_o)
   );

   always #5 clk = ~clk;

   // Strobe bit positions in the packed observation word.
   localparam logic [11:0] PCW  = 12'h800;
   localparam logic [11:0] IRW  = 12'h400;
   localparam logic [11:0] IORD = 12'h200;
   localparam logic [11:0] MR   = 12'h100;
   localparam logic [11:0] MW   = 12'h080;
   localparam logic [11:0] RW   = 12'h040;
   localparam logic [11:0] M2R  = 12'h020;
   localparam logic [11:0] BR   = 12'h010;
   localparam logic [11:0] JMP  = 12'h008;
   localparam logic [11:0] IPR  = 12'h004;
   localparam logic [11:0] AS   = 12'h002;
   localparam logic [11:0] TRP  = 12'h001;

   typedef struct packed {
      logic [6:0]  op;
      logic        rdy;
      logic [17:0] exp;
   } vec_t;

   function automatic logic [17:0] E(input int st, input int alu, input logic [11:0] s);
      return {3'(st), 3'(alu), s};
   endfunction

   function automatic vec_t V(input logic [6:0] op, input logic rdy, input logic [17:0] exp);
      return '{op, rdy, exp};
   endfunction

   function automatic logic [17:0] observe();
      return {State_o, ALU_Op_o, PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o,
              Mem_Write_o, Reg_Write_o, Mem_to_Reg_o, Branch_o, Jump_o,
              Imm_plus_reg_o, ALU_Src_o, Trap_o};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] got;
      reset = 1'b1; OP_i = 7'h33; Mem_Ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         got = observe(); tests++;
         if (got !== E(0, 6, MR)) begin
            fails++; $display("FAIL reset_hold[%0d]: got %h expected %h", i, got, E(0, 6, MR));
         end
      end
      reset = 1'b0; #1;
      got = observe(); tests++;
      if (got !== E(0, 6, PCW | IRW | MR)) begin
         fails++; $display("FAIL reset_release: got %h expected %h", got, E(0, 6, PCW | IRW | MR));
      end
      // Walk a LOAD into MEM, then reset mid-access.
      OP_i = 7'h03;
      repeat (3) begin @(posedge clk); #1; end
      Mem_Ready_i = 1'b0; reset = 1'b1; #1;
      got = observe(); tests++;
      if (got !== E(3, 6, MR)) begin
         fails++; $display("FAIL reset_mid_mem: got %h expected %h", got, E(3, 6, MR));
      end
      @(posedge clk); #1; reset = 1'b0; #1;
      got = observe(); tests++;
      if (got !== E(0, 6, MR)) begin
         fails++; $display("FAIL reset_after_mem: got %h expected %h", got, E(0, 6, MR));
      end
   endtask

   task automatic test_r_type();
      vec_t q[$];
      logic [17:0] got;
      q = {V(7'h33, 1, E(0, 6, PCW | IRW | MR)), V(7'h33, 1, E(1, 0, 0)),
           V(7'h33, 1, E(2, 0, 0)), V(7'h33, 1, E(4, 0, RW)),
           V(7'h33, 1, E(0, 6, PCW | IRW | MR))};
      do_reset();
      foreach (q[i]) begin
         OP_i = q[i].op; Mem_Ready_i = q[i].rdy; #1;
         got = observe(); tests++;
         if (got !== q[i].exp) begin
            fails++; $display("FAIL r_type step %0d: got %h expected %h", i, got, q[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   // OP_i goes illegal after DECODE: EXEC/MEM/WB must follow the latched LOAD class.
   task automatic test_load_wait();
      vec_t q[$];
      logic [17:0] got;
      q = {V(7'h03, 1, E(0, 6, PCW | IRW | MR)), V(7'h03, 1, E(1, 0, 0)),
           V(7'h7F, 1, E(2, 6, AS)),
           V(7'h7F, 0, E(3, 0, IORD | MR | AS)), V(7'h7F, 0, E(3, 0, IORD | MR | AS)),
           V(7'h7F, 1, E(3, 0, IORD | MR | AS)),
           V(7'h7F, 0, E(4, 0, RW | M2R)), V(7'h7F, 0, E(0, 6, MR))};
      do_reset();
      foreach (q[i]) begin
         OP_i = q[i].op; Mem_Ready_i = q[i].rdy; #1;
         got = observe(); tests++;
         if (got !== q[i].exp) begin
            fails++; $display("FAIL load_wait step %0d: got %h expected %h", i, got, q[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store();
      vec_t q[$];
      logic [17:0] got;
      q = {V(7'h23, 1, E(0, 6, PCW | IRW | MR)), V(7'h23, 1, E(1, 0, 0)),
           V(7'h33, 0, E(2, 5, AS)), V(7'h33, 1, E(3, 0, IORD | MW | AS)),
           V(7'h33, 0, E(0, 6, MR))};
      do_reset();
      foreach (q[i]) begin
         OP_i = q[i].op; Mem_Ready_i = q[i].rdy; #1;
         got = observe(); tests++;
         if (got !== q[i].exp) begin
            fails++; $display("FAIL store step %0d: got %h expected %h", i, got, q[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_exec_classes();
      logic [6:0]  ops[5]    = '{7'h63, 7'h67, 7'h6F, 7'h13, 7'h37};
      logic [17:0] ex_exp[5] = '{E(2, 3, BR), E(2, 4, PCW | JMP | IPR | AS),
                                 E(2, 7, PCW | JMP | AS), E(2, 1, AS), E(2, 2, AS)};
      logic        has_wb[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vec_t q[$];
      logic [17:0] got;
      for (int k = 0; k < 5; k++) begin
         q = {V(ops[k], 1, E(0, 6, PCW | IRW | MR)), V(ops[k], 1, E(1, 0, 0)),
              V(ops[k], 1, ex_exp[k])};
         if (has_wb[k]) q.push_back(V(ops[k], 0, E(4, 0, RW)));
         q.push_back(V(ops[k], 0, E(0, 6, MR)));
         do_reset();
         foreach (q[i]) begin
            OP_i = q[i].op; Mem_Ready_i = q[i].rdy; #1;
            got = observe(); tests++;
            if (got !== q[i].exp) begin
               fails++;
               $display("FAIL exec_op%h step %0d: got %h expected %h", ops[k], i, got, q[i].exp);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_illegal_trap();
      vec_t q[$];
      logic [17:0] got;
      q = {V(7'h7F, 1, E(0, 6, PCW | IRW | MR)), V(7'h7F, 1, E(1, 0, 0))};
      for (int i = 0; i < 20; i++) q.push_back(V(7'h33, 1'(i), E(5, 0, TRP)));
      do_reset();
      foreach (q[i]) begin
         OP_i = q[i].op; Mem_Ready_i = q[i].rdy; #1;
         got = observe(); tests++;
         if (got !== q[i].exp) begin
            fails++; $display("FAIL illegal_trap step %0d: got %h expected %h", i, got, q[i].exp);
         end
         @(posedge clk); #1;
      end
      Mem_Ready_i = 1'b0;
      do_reset(); #1;
      got = observe(); tests++;
      if (got !== E(0, 6, MR)) begin
         fails++; $display("FAIL trap_cleared: got %h expected %h", got, E(0, 6, MR));
      end
   endtask

   // Scenario 0: FETCH times out; 1: ready on the 16th wait cycle wins; 2: MEM times out.
   task automatic test_timeout();
      vec_t q[$];
      logic [17:0] got;
      for (int s = 0; s < 3; s++) begin
         q.delete();
         if (s == 0) begin
            for (int i = 0; i < 16; i++) q.push_back(V(7'h33, 0, E(0, 6, MR)));
            q.push_back(V(7'h33, 1, E(5, 0, TRP)));
         end else if (s == 1) begin
            for (int i = 0; i < 15; i++) q.push_back(V(7'h33, 0, E(0, 6, MR)));
            q.push_back(V(7'h33, 1, E(0, 6, PCW | IRW | MR)));
            q.push_back(V(7'h33, 0, E(1, 0, 0)));
         end else begin
            q = {V(7'h03, 1, E(0, 6, PCW | IRW | MR)), V(7'h03, 1, E(1, 0, 0)),
                 V(7'h03, 0, E(2, 6, AS))};
            for (int i = 0; i < 16; i++) q.push_back(V(7'h03, 0, E(3, 0, IORD | MR | AS)));
            q.push_back(V(7'h03, 1, E(5, 0, TRP)));
         end
         do_reset();
         foreach (q[i]) begin
            OP_i = q[i].op; Mem_Ready_i = q[i].rdy; #1;
            got = observe(); tests++;
            if (got !== q[i].exp) begin
               fails++;
               $display("FAIL timeout_s%0d step %0d: got %h expected %h", s, i, got, q[i].exp);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load_wait();
      test_store();
      test_exec_classes();
      test_illegal_trap();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
